fp_add_issue: RTL

Operand-issue and result-capture stage placed directly upstream of the floating-point adder (`FloatingAddition`) in the Floating ALU. It buffers IEEE-754 single-precision operand pairs in a small queue and issues them one at a time to the adder over its `EN`/`A`/`B` inputs. It waits for `Flag_ADD`, captures `OUT_ADD`, classifies the result and presents it on a valid/ready output. A watchdog guards against an adder that never completes.

---
 rtl/fp_pkg.sv | 53 +++++
 rtl/fp_operand_fifo.sv | 55 +++++
 rtl/fp_add_issue.sv | 118 +++++++++++
 3 files changed

// File: rtl/fp_pkg.sv
// Shared types and constants for the floating-point adder issue stage.
// Covers FSM states, result classes and the operand-pair layout.
package fp_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_HOLD
    } state_t;

    typedef enum logic [2:0] {
        CLS_NORMAL  = 3'b000,
        CLS_ZERO    = 3'b001,
        CLS_PINF    = 3'b010,
        CLS_NINF    = 3'b011,
        CLS_NAN     = 3'b100,
        CLS_SUBN    = 3'b101,
        CLS_TIMEOUT = 3'b110
    } res_class_t;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
    } fp_pair_t;

    localparam logic [31:0] FP_QNAN    = 32'h7FC00000;
    localparam logic [7:0]  FP_EXP_MAX = 8'hFF;

    function automatic res_class_t fp_classify(input logic [31:0] w);
        logic [7:0]  e;
        logic [22:0] m;
        res_class_t  c;
        e = w[30:23];
        m = w[22:0];
        c = CLS_NORMAL;
        if (e == FP_EXP_MAX) begin
            if (m != '0)
                c = CLS_NAN;
            else if (w[31])
                c = CLS_NINF;
            else
                c = CLS_PINF;
        end else if (e == '0) begin
            if (m != '0)
                c = CLS_SUBN;
            else
                c = CLS_ZERO;
        end
        return c;
    endfunction

endpackage

// File: rtl/fp_operand_fifo.sv
// Power-of-two synchronous FIFO holding operand pairs for the adder.
// Wrapping pointers plus an occupancy count give full/empty directly.
module fp_operand_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 64
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] wdata,
    output logic [W-1:0] rdata,
    output logic         full,
    output logic         empty
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge CLK) begin
        if (do_push)
            mem[wr_ptr] <= wdata;
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)
                rd_ptr <= rd_ptr + AW'(1);
            unique case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/fp_add_issue.sv
// Issues queued operand pairs to the FP adder one at a time and
// captures, classifies and holds each result for the consumer.
module fp_add_issue
    import fp_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 15
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_a,
    input  logic [31:0] in_b,
    output logic        add_en,
    output logic [31:0] add_a,
    output logic [31:0] add_b,
    input  logic [31:0] add_out,
    input  logic        add_flag,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [31:0] res_data,
    output logic [2:0]  res_class,
    output logic        busy,
    output logic        timeout_err
);

    localparam int CW = $clog2(TIMEOUT + 1);

    state_t     state;
    logic [CW-1:0] wd_cnt;
    fp_pair_t   wr_pair;
    fp_pair_t   head;
    logic       full;
    logic       empty;
    logic       push;
    logic       pop;
    res_class_t cls;

    assign in_ready = !full;
    assign push     = in_valid && in_ready;
    assign pop      = (state == ST_ISSUE);
    assign wr_pair  = {in_a, in_b};
    assign busy     = (state != ST_IDLE) || !empty;

    always_comb begin
        cls = fp_classify(add_out);
    end

    fp_operand_fifo #(
        .DEPTH(DEPTH),
        .W    (64)
    ) u_fifo (
        .CLK  (CLK),
        .RST  (RST),
        .push (push),
        .pop  (pop),
        .wdata(wr_pair),
        .rdata(head),
        .full (full),
        .empty(empty)
    );

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state       <= ST_IDLE;
            wd_cnt      <= '0;
            add_en      <= 1'b0;
            add_a       <= '0;
            add_b       <= '0;
            res_valid   <= 1'b0;
            res_data    <= '0;
            res_class   <= CLS_NORMAL;
            timeout_err <= 1'b0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (!empty)
                        state <= ST_ISSUE;
                end
                ST_ISSUE: begin
                    add_a  <= head.a;
                    add_b  <= head.b;
                    add_en <= 1'b1;
                    wd_cnt <= '0;
                    state  <= ST_WAIT;
                end
                ST_WAIT: begin
                    // A completion on the final watchdog cycle still wins.
                    if (add_flag) begin
                        res_data  <= add_out;
                        res_class <= cls;
                        add_en    <= 1'b0;
                        res_valid <= 1'b1;
                        state     <= ST_HOLD;
                    end else if (wd_cnt == CW'(TIMEOUT)) begin
                        res_data    <= FP_QNAN;
                        res_class   <= CLS_TIMEOUT;
                        timeout_err <= 1'b1;
                        add_en      <= 1'b0;
                        res_valid   <= 1'b1;
                        state       <= ST_HOLD;
                    end else begin
                        wd_cnt <= wd_cnt + CW'(1);
                    end
                end
                ST_HOLD: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        state     <= empty ? ST_IDLE : ST_ISSUE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
